// File: rtl/gates_pkg.sv
// Shared definitions for the gate sweep controller.
//   sweep_state_e : sequencer states (IDLE -> SETTLE -> SAMPLE ... -> FINISH).
//   TT_*          : expected truth tables for common 2-input gates.
//                   Bit i is the expected output when the drive vector is i,
//                   where vector bit 0 is input A and bit 1 is input B.
package gates_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } sweep_state_e;

  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_XOR2  = 4'b0110;

endpackage

// File: rtl/gate_settle_timer.sv
// 8-bit load/count/expire timer that paces the SETTLE phase.
//   clk, rst : clock and asynchronous active-high reset
//   load     : restart the count from zero (wins over en)
//   en       : count one cycle of settling
//   limit    : terminal count, i.e. settle length minus one
//   expire   : high during the last enabled cycle of the settle window
module gate_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] limit,
  output logic       expire
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= '0;
    else if (en)   cnt <= cnt + 8'd1;
  end

  // Count starts at 0 on the first settle cycle, so the window ends when
  // the count reaches limit: limit+1 enabled cycles in total.
  assign expire = en && (cnt == limit);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Clocked truth-table sweeper for a combinational gate.
// Drives every input vector in ascending order, holds each for SETTLE_CYCLES
// cycles, samples the gate output X once and compares it against a truth
// table captured at START.
//   CLK, RST : clock, asynchronous active-high reset
//   START    : begin a sweep (accepted only in IDLE)
//   TT       : expected truth table, TT[i] = expected X for vector i
//   X        : gate output under test
//   IN_VEC   : drive vector (bit 0 = A, bit 1 = B, ...)
//   BUSY     : sweep in progress
//   DONE     : one-cycle end-of-sweep pulse
//   PASS     : last sweep had no mismatches (updated as DONE ends)
//   ERR_CNT  : saturating mismatch count
//   FAIL_IDX : first mismatching vector, meaningful when ERR_CNT != 0
// SETTLE_CYCLES must lie in 1..255 (the settle timer is 8 bits).
module gate_sweep_ctrl
  import gates_pkg::*;
#(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [2**N_IN-1:0]   TT,
  input  logic                 X,
  output logic [N_IN-1:0]      IN_VEC,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic [N_IN:0]        ERR_CNT,
  output logic [N_IN-1:0]      FAIL_IDX
);

  localparam int              NVEC       = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_IDX   = {N_IN{1'b1}};
  localparam logic [7:0]      SETTLE_LIM = 8'(SETTLE_CYCLES - 1);

  sweep_state_e      state;
  logic [NVEC-1:0]   tt_q;
  logic [N_IN-1:0]   idx;
  logic              accept;
  logic              last_vec;
  logic              mismatch;
  logic              tmr_load;
  logic              tmr_en;
  logic              tmr_expire;

  assign accept   = (state == IDLE) && START;
  assign last_vec = (idx == LAST_IDX);

  // Case-equality so an unknown or floating gate output is reported as a
  // mismatch in four-state simulation instead of silently matching.
  assign mismatch = (X !== tt_q[idx]);

  // The timer is restarted whenever a new vector goes out: on the accepted
  // START and on every non-terminal SAMPLE.
  assign tmr_load = accept || ((state == SAMPLE) && !last_vec);
  assign tmr_en   = (state == SETTLE);

  gate_settle_timer u_timer (
    .clk    (CLK),
    .rst    (RST),
    .load   (tmr_load),
    .en     (tmr_en),
    .limit  (SETTLE_LIM),
    .expire (tmr_expire)
  );

  // DONE lives exactly for the single FINISH cycle; FINISH is not IDLE, so
  // a START coinciding with DONE is ignored.
  assign DONE = (state == FINISH);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      tt_q     <= '0;
      idx      <= '0;
      IN_VEC   <= '0;
      BUSY     <= 1'b0;
      PASS     <= 1'b0;
      ERR_CNT  <= '0;
      FAIL_IDX <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            tt_q     <= TT;
            idx      <= '0;
            IN_VEC   <= '0;
            ERR_CNT  <= '0;
            FAIL_IDX <= '0;
            PASS     <= 1'b0;
            BUSY     <= 1'b1;
            state    <= SETTLE;
          end
        end

        SETTLE: begin
          if (tmr_expire) state <= SAMPLE;
        end

        SAMPLE: begin
          if (mismatch) begin
            if (!(&ERR_CNT)) ERR_CNT <= ERR_CNT + 1'b1;
            if (ERR_CNT == '0) FAIL_IDX <= idx;
          end
          // Terminal compare happens before the increment, so idx never
          // wraps and IN_VEC is left at all-ones after the sweep.
          if (last_vec) begin
            state <= FINISH;
          end else begin
            idx    <= idx + 1'b1;
            IN_VEC <= idx + 1'b1;
            state  <= SETTLE;
          end
        end

        FINISH: begin
          BUSY  <= 1'b0;
          PASS  <= (ERR_CNT == '0);
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: a behavioural 2-input gate sits on
// the drive vector, and a second instance with a one-cycle settle time
// samples a floating gate output.
module tb_gate_sweep_ctrl;
  import gates_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START, START1;
  logic [3:0] TT, TT1;
  logic       X, X1;
  logic [1:0] IN_VEC, IN_VEC1;
  logic       BUSY, DONE, PASS, BUSY1, DONE1, PASS1;
  logic [2:0] ERR_CNT, ERR_CNT1;
  logic [1:0] FAIL_IDX, FAIL_IDX1;

  int   gsel;      // 0 NOR, 1 AND, 2 OR
  logic x_tie;     // floating gate output for the second instance
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  always_comb begin
    case (gsel)
      0:       X = ~(IN_VEC[0] | IN_VEC[1]);
      1:       X = IN_VEC[0] & IN_VEC[1];
      default: X = IN_VEC[0] | IN_VEC[1];
    endcase
  end
  assign X1 = x_tie;

  gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .START(START), .TT(TT), .X(X), .IN_VEC(IN_VEC),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_CNT(ERR_CNT), .FAIL_IDX(FAIL_IDX)
  );

  gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(1)) dut1 (
    .CLK(CLK), .RST(RST), .START(START1), .TT(TT1), .X(X1), .IN_VEC(IN_VEC1),
    .BUSY(BUSY1), .DONE(DONE1), .PASS(PASS1), .ERR_CNT(ERR_CNT1), .FAIL_IDX(FAIL_IDX1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Pulse START for one edge; returns in cycle 1 of the sweep.
  task automatic kick();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  // Advance until DONE, bounded; c is the sweep cycle number DONE appeared in.
  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (DONE !== 1'b1 && c < 60) begin
      step();
      c++;
    end
  endtask

  initial begin
    int c, dones, done_cyc, exp_err, exp_fail;
    bit found;
    RST = 1'b1; START = 1'b0; START1 = 1'b0;
    TT = TT_NOR2; TT1 = TT_XOR2; gsel = 0; x_tie = 1'bz;
    step(); step();

    // Reset state
    chk("rst_in_vec", 32'(IN_VEC), 0);
    chk("rst_busy",   32'(BUSY), 0);
    chk("rst_done",   32'(DONE), 0);
    chk("rst_pass",   32'(PASS), 0);
    chk("rst_err",    32'(ERR_CNT), 0);
    chk("rst_fidx",   32'(FAIL_IDX), 0);
    RST = 1'b0;
    step();

    // 1: NOR gate, matching table; each vector held 3 cycles, DONE in cycle 13
    gsel = 0; TT = TT_NOR2;
    kick();
    chk("t1_busy", 32'(BUSY), 1);
    for (int k = 1; k <= 12; k++) begin
      chk($sformatf("t1_vec_c%0d", k), 32'(IN_VEC), 32'((k - 1) / 3));
      if (DONE) chk("t1_early_done", 32'(k), 13);
      step();
    end
    chk("t1_done", 32'(DONE), 1);
    step();
    chk("t1_done_clr", 32'(DONE), 0);
    chk("t1_busy_clr", 32'(BUSY), 0);
    chk("t1_pass",     32'(PASS), 1);
    chk("t1_err",      32'(ERR_CNT), 0);
    chk("t1_vec_hold", 32'(IN_VEC), 3);

    // 2: AND gate against NOR table -> mismatch at 0 and 3
    gsel = 1; TT = TT_NOR2;
    kick();
    wait_done(1, c);
    chk("t2_lat", 32'(c), 13);
    step();
    chk("t2_err",  32'(ERR_CNT), 2);
    chk("t2_fidx", 32'(FAIL_IDX), 0);
    chk("t2_pass", 32'(PASS), 0);

    // 3: async reset in cycle 7, then an OR sweep
    gsel = 0; TT = TT_NOR2;
    kick();
    repeat (6) step();
    chk("t3_pre_vec", 32'(IN_VEC), 2);
    RST = 1'b1;
    #1;
    chk("t3_rst_vec",  32'(IN_VEC), 0);
    chk("t3_rst_busy", 32'(BUSY), 0);
    chk("t3_rst_done", 32'(DONE), 0);
    chk("t3_rst_pass", 32'(PASS), 0);
    chk("t3_rst_err",  32'(ERR_CNT), 0);
    chk("t3_rst_fidx", 32'(FAIL_IDX), 0);
    step();
    RST = 1'b0;
    step();
    gsel = 2; TT = TT_OR2;
    kick();
    wait_done(1, c);
    chk("t3_lat", 32'(c), 13);
    step();
    chk("t3_pass", 32'(PASS), 1);
    chk("t3_err",  32'(ERR_CNT), 0);

    // 4: START re-pulsed in cycles 3 and 8 is ignored
    gsel = 0; TT = TT_NOR2;
    kick();
    dones = 0; done_cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      START = (k == 3 || k == 8);
      if (DONE) begin
        dones++;
        done_cyc = k;
      end
      step();
    end
    START = 1'b0;
    chk("t4_dones",    32'(dones), 1);
    chk("t4_done_cyc", 32'(done_cyc), 13);
    chk("t4_pass",     32'(PASS), 1);
    chk("t4_busy",     32'(BUSY), 0);

    // 5: TT changed mid-sweep has no effect
    gsel = 0; TT = TT_NOR2;
    kick();
    repeat (3) step();
    TT = 4'b1111;
    wait_done(4, c);
    chk("t5_lat", 32'(c), 13);
    step();
    chk("t5_pass", 32'(PASS), 1);
    chk("t5_err",  32'(ERR_CNT), 0);
    TT = TT_NOR2;

    // 6: floating gate output, one-cycle settle. With four-state values a
    // floating output mismatches every vector (4 errors, first at 0); a
    // two-state simulator resolves the float to a constant, so the expected
    // count follows whatever value the floating net actually presents.
    exp_err = 0; exp_fail = 0; found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (x_tie !== TT1[i]) begin
        if (!found) exp_fail = i;
        found = 1'b1;
        exp_err++;
      end
    end
    START1 = 1'b1;
    step();
    START1 = 1'b0;
    c = 1;
    while (DONE1 !== 1'b1 && c < 60) begin
      step();
      c++;
    end
    chk("t6_lat", 32'(c), 9);
    step();
    chk("t6_err",  32'(ERR_CNT1), 32'(exp_err));
    chk("t6_fidx", 32'(FAIL_IDX1), 32'(exp_fail));
    chk("t6_pass", 32'(PASS1), 32'(exp_err == 0));
    chk("t6_vec",  32'(IN_VEC1), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
